// File: rtl/fpu_cvt_pkg.sv
// Shared types for the FPU float/int conversion path.
package fpu_cvt_pkg;

   typedef enum logic {
      CVT_FTOI = 1'b0,
      CVT_ITOF = 1'b1
   } cvt_op_e;

   localparam int unsigned CVT_TAG_W = 5;

   typedef struct packed {
      logic [CVT_TAG_W-1:0] tag;
      logic [31:0]          data;
   } cvt_res_t;

endpackage

// File: rtl/fpu_cvt_unit_fifo.sv
// Result FIFO for the conversion unit: synchronous, DEPTH entries, async active-low reset.
module cvt_result_fifo
   import fpu_cvt_pkg::*;
#(
   parameter int unsigned DEPTH = 3
) (
   input  logic     clk,
   input  logic     rstn,
   input  logic     push,
   input  cvt_res_t wdata,
   input  logic     pop,
   output cvt_res_t rdata,
   output logic     full,
   output logic     empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   cvt_res_t        mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW-1:0]   wr_nxt, rd_nxt;
   logic [CW-1:0]   count;
   logic            do_pop;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign rdata  = mem[rd_ptr];
   assign do_pop = pop & ~empty;

   always_comb begin
      wr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      rd_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_nxt;
         end
         if (do_pop) rd_ptr <= rd_nxt;
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn) !(push && full));

endmodule

// File: rtl/ftoi.sv
// Registered float32 -> signed int32 converter: truncates toward zero, saturates on overflow/NaN.
module ftoi (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] a,
   output logic [31:0] y
);

   localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   logic        sgn;
   logic [7:0]  expo;
   logic [54:0] wide;
   logic [31:0] mag;
   logic [31:0] res;

   always_comb begin
      sgn  = a[31];
      expo = a[30:23];
      wide = '0;
      mag  = '0;
      res  = '0;
      if (expo == 8'hFF) begin
         res = ((a[22:0] != '0) || !sgn) ? INT_MAX : INT_MIN;
      end else if (expo >= 8'd158) begin
         res = sgn ? INT_MIN : INT_MAX;
      end else if (expo >= 8'd127) begin
         // Integer part is the 24-bit significand shifted by the unbiased exponent, binary point at bit 23.
         wide = {31'b0, 1'b1, a[22:0]} << (expo - 8'd127);
         mag  = 32'(wide >> 23);
         res  = sgn ? -mag : mag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) y <= '0;
      else       y <= res;
   end

endmodule

// File: rtl/itof.sv
// Registered signed int32 -> float32 converter, round-to-nearest-even.
module itof (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] a,
   output logic [31:0] y
);

   logic        sgn;
   logic [31:0] mag;
   logic [4:0]  lead;
   logic [30:0] norm;
   logic [7:0]  expo;
   logic        rnd;
   logic [31:0] res;

   always_comb begin
      sgn  = a[31];
      mag  = sgn ? -a : a;
      lead = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (mag[i]) lead = 5'(i);
      end
      norm = 31'(mag << (5'd31 - lead));
      expo = 8'd127 + {3'b000, lead};
      rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
      // A mantissa carry from rounding ripples into the exponent field, which is the correct result.
      res  = (mag == '0) ? '0 : ({sgn, expo, norm[30:8]} + {31'b0, rnd});
   end

   always_ff @(posedge clk) begin
      if (!rstn) y <= '0;
      else       y <= res;
   end

endmodule

// File: rtl/fpu_cvt_unit.sv
// FCVT execution wrapper: credit-admitted ops through non-stalling converters into a tagged result FIFO.
module fpu_cvt_unit
   import fpu_cvt_pkg::*;
#(
   parameter int unsigned TAG_W = CVT_TAG_W,
   parameter int unsigned DEPTH = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [31:0]      out_data,
   output logic             busy
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [CW-1:0]    cnt;
   logic             accept, pop;
   logic             s1_valid;
   cvt_op_e          s1_op;
   logic [TAG_W-1:0] s1_tag;
   logic [31:0]      ftoi_y, itof_y;
   cvt_res_t         push_res, head;
   logic             fifo_full, fifo_empty;

   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign in_ready  = (cnt < CW'(DEPTH));
   assign busy      = (cnt != '0);
   assign out_valid = ~fifo_empty;
   // The FIFO tag field is sized by the package; TAG_W is expected to match it.
   assign out_tag   = TAG_W'(head.tag);
   assign out_data  = head.data;

   always_comb begin
      push_res.tag  = CVT_TAG_W'(s1_tag);
      push_res.data = (s1_op == CVT_FTOI) ? ftoi_y : itof_y;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt      <= '0;
         s1_valid <= 1'b0;
         s1_op    <= CVT_FTOI;
         s1_tag   <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_op  <= cvt_op_e'(in_op);
            s1_tag <= in_tag;
         end
         case ({accept, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   ftoi u_ftoi (
      .clk  (clk),
      .rstn (rstn),
      .a    (in_data),
      .y    (ftoi_y)
   );

   itof u_itof (
      .clk  (clk),
      .rstn (rstn),
      .a    (in_data),
      .y    (itof_y)
   );

   cvt_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (s1_valid),
      .wdata (push_res),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Every FIFO entry holds a credit, so a full FIFO means all credits are outstanding.
   a_full_implies_no_credit: assert property (@(posedge clk) disable iff (!rstn) fifo_full |-> (cnt == CW'(DEPTH)));

endmodule

// File: tb/tb_fpu_cvt_unit.sv
// Randomized self-checking bench for fpu_cvt_unit against a real-arithmetic conversion model.
module tb_fpu_cvt_unit;

   localparam int unsigned TAG_W = 5;
   localparam int unsigned DEPTH = 3;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_op = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic [31:0]      in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [TAG_W-1:0] out_tag;
   logic [31:0]      out_data;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      int               cyc;
   } exp_t;
   exp_t exp_q[$];

   fpu_cvt_unit #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tag   (out_tag),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Float value is rebuilt as a double so the host's real arithmetic does the truncation.
   function automatic logic [31:0] ref_ftoi(input logic [31:0] a);
      logic [10:0] de;
      real         r;
      if (a[30:23] == 8'hFF) return (a[22:0] != 0 || !a[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      if (a[30:23] == 8'h00) return 32'h0;
      de = {3'b000, a[30:23]} + 11'd896;
      r  = $bitstoreal({a[31], de, a[22:0], 29'b0});
      if (r >= 2147483648.0) return 32'h7FFF_FFFF;
      if (r < -2147483648.0) return 32'h8000_0000;
      return $rtoi(r);
   endfunction

   // The integer is exact as a double; narrow the double to single with round-to-nearest-even.
   function automatic logic [31:0] ref_itof(input logic [31:0] a);
      logic [63:0] db;
      logic [10:0] fe;
      logic        g, st, up;
      if (a == 0) return 32'h0;
      db = $realtobits($itor($signed(a)));
      fe = db[62:52] - 11'd896;
      g  = db[28];
      st = |db[27:0];
      up = g & (st | db[29]);
      return {db[63], fe[7:0], db[51:29]} + {31'b0, up};
   endfunction

   function automatic logic [31:0] ref_conv(input logic op, input logic [31:0] a);
      return op ? ref_itof(a) : ref_ftoi(a);
   endfunction

   function automatic logic [31:0] rand_operand(input logic op);
      logic [31:0] r;
      if (!op) begin
         if ($urandom_range(3) == 0) r = $urandom;
         else r = {1'($urandom), 8'($urandom_range(165, 110)), 23'($urandom)};
      end else begin
         case ($urandom_range(2))
            0:       r = $urandom;
            1:       r = 32'($urandom_range(2000)) - 32'd1000;
            default: r = 32'($urandom) >> $urandom_range(31);
         endcase
      end
      return r;
   endfunction

   // Scoreboard: handshakes sampled mid-cycle take effect at the following edge.
   always @(negedge clk) begin
      bit vis, rdy_m;
      cyc++;
      if (!rstn) begin
         exp_q.delete();
         check_eq("rst_out_valid", out_valid, 0);
         check_eq("rst_busy", busy, 0);
      end else begin
         vis   = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
         rdy_m = exp_q.size() < DEPTH;
         check_eq("in_ready", in_ready, rdy_m);
         check_eq("busy", busy, exp_q.size() != 0);
         check_eq("out_valid", out_valid, vis);
         if (vis) begin
            check_eq("out_tag", out_tag, exp_q[0].tag);
            check_eq("out_data", out_data, exp_q[0].data);
            if (out_ready) void'(exp_q.pop_front());
         end
         if (in_valid && rdy_m) exp_q.push_back('{in_tag, ref_conv(in_op, in_data), cyc});
      end
   end

   task automatic single_op(input logic op, input logic [31:0] d, input logic [TAG_W-1:0] tag,
                            input logic [31:0] exp);
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = op; in_tag = tag; in_data = d; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = $urandom;
      check_eq("no_bypass", out_valid, 0);
      @(posedge clk); #1;
      check_eq("lat_valid", out_valid, 1);
      check_eq("lat_tag", out_tag, tag);
      check_eq("lat_data", out_data, exp);
      @(posedge clk); #1;
      check_eq("popped", out_valid, 0);
   endtask

   task automatic drive_random(input int vprob, input int rprob);
      @(posedge clk); #1;
      in_valid  = ($urandom_range(99) < vprob);
      in_op     = 1'($urandom);
      in_tag    = TAG_W'($urandom);
      in_data   = rand_operand(in_op);
      out_ready = ($urandom_range(99) < rprob);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (!busy && !out_valid) break;
      end
      check_eq("drain_left", exp_q.size(), 0);
      check_eq("drain_ready", in_ready, 1);
   endtask

   initial begin
      int acc;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_busy_rel", busy, 0);
      check_eq("rst_tag", out_tag, 0);
      check_eq("rst_data", out_data, 0);

      single_op(1'b0, 32'h4040_0000, 5'd5,  32'h0000_0003);
      single_op(1'b0, 32'hC040_0000, 5'd6,  32'hFFFF_FFFD);
      single_op(1'b1, 32'h0000_0001, 5'd7,  32'h3F80_0000);
      single_op(1'b1, 32'hFFFF_FFFF, 5'd8,  32'hBF80_0000);
      single_op(1'b0, 32'h7FC0_0000, 5'd9,  32'h7FFF_FFFF);
      single_op(1'b0, 32'h4F00_0000, 5'd10, 32'h7FFF_FFFF);
      single_op(1'b0, 32'hCF00_0000, 5'd11, 32'h8000_0000);
      single_op(1'b0, 32'h3F00_0000, 5'd12, 32'h0000_0000);
      single_op(1'b1, 32'h8000_0000, 5'd13, 32'hCF00_0000);
      single_op(1'b1, 32'h0100_0001, 5'd14, 32'h4B80_0000);
      single_op(1'b1, 32'h0100_0003, 5'd15, 32'h4B80_0002);
      single_op(1'b1, 32'h0000_0000, 5'd16, 32'h0000_0000);

      // Back-to-back stream with writeback always ready.
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         check_eq("stream_ready", in_ready, 1);
         in_valid  = 1'b1;
         in_op     = 1'($urandom);
         in_tag    = TAG_W'(i);
         in_data   = rand_operand(in_op);
         out_ready = 1'b1;
      end
      drain();

      // Backpressure: only DEPTH ops get in while writeback stalls.
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_op    = 1'($urandom);
         in_tag   = TAG_W'($urandom);
         in_data  = rand_operand(in_op);
         @(negedge clk);
         if (in_valid && in_ready) acc++;
      end
      check_eq("bp_accepts", acc, DEPTH);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_busy", busy, 1);
      check_eq("bp_head_data", out_data, exp_q[0].data);
      check_eq("bp_head_tag", out_tag, exp_q[0].tag);
      drain();

      // Random valid/ready mix: full-FIFO push/pop overlap and pointer wrap.
      for (int i = 0; i < 150; i++) drive_random(70, 60);
      drain();
      for (int i = 0; i < 60; i++) drive_random(90, 85);
      drain();

      // Asynchronous reset between edges while results are buffered.
      for (int i = 0; i < 4; i++) drive_random(100, 0);
      @(posedge clk); #3;
      rstn = 1'b0;
      in_valid = 1'b0;
      #1;
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_data", out_data, 0);
      @(posedge clk); #3;
      rstn = 1'b1;
      #1;
      check_eq("post_rst_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      single_op(1'b0, 32'h4040_0000, 5'd21, 32'h0000_0003);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
